phase_bus_reader: RTL

- Bus-side reader for the traffic controller's phase-duration register slots.
- Each slot is a load/enable D-type register that drives a shared bus on request.
- On start, the block polls every slot in turn, captures each duration into an internal table, then sequences traffic phases continuously, holding each phase for its captured number of cycles.
- Sits between the duration register bank and the light-decode logic.

---
 rtl/phase_bus_reader_pkg.sv | 21 ++
 rtl/phase_bus_reader_if.sv | 39 +++
 rtl/phase_bus_reader_timer.sv | 40 ++++
 rtl/phase_bus_reader.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/phase_bus_reader_pkg.sv
// rtl/phase_bus_reader_pkg.sv - shared types and helpers for the phase-duration bus reader
// Purpose: FSM state encoding, phase-index width helper and the default
//          substitute duration used when ZERO_DUR_SUBST_EN is defined.
// Ports:   none (package).
package phase_bus_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int DEFAULT_DUR_DEF = 8;

  // Width of a slot / phase index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_bus_reader_if.sv
// rtl/phase_bus_reader_if.sv - slot bus and phase outputs of the reader as one bundle
// Purpose: groups the control pulses, the shared slot bus and the phase
//          status outputs of phase_bus_reader.
// Ports (master = reader side):
//   start, reload   in   one-cycle control pulses
//   bus_data        in   shared duration bus driven by the selected slot
//   slot_rd         out  one-hot slot read request
//   loading         out  high while slots are being read
//   phase_active    out  high while phases are sequencing
//   phase_idx       out  current phase number
//   phase_end       out  pulse in the last cycle of each phase
interface phase_bus_reader_if
  import phase_bus_reader_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int DATA_W     = 8
);
  localparam int IW = idx_width(NUM_PHASES);

  logic                  start;
  logic                  reload;
  logic [DATA_W-1:0]     bus_data;
  logic [NUM_PHASES-1:0] slot_rd;
  logic                  loading;
  logic                  phase_active;
  logic [IW-1:0]         phase_idx;
  logic                  phase_end;

  modport master (
    input  start, reload, bus_data,
    output slot_rd, loading, phase_active, phase_idx, phase_end
  );

  modport slave (
    output start, reload, bus_data,
    input  slot_rd, loading, phase_active, phase_idx, phase_end
  );

endinterface

// File: rtl/phase_bus_reader_timer.sv
// rtl/phase_bus_reader_timer.sv - loadable down-counter timing one traffic phase
// Purpose: counts a phase down from (duration-1); zero is a registered flag
//          that is high exactly in the cycle the count is 0.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         synchronous clear (count 0, flag low) while not sequencing
//   load        load strobe, load_val is the new count
//   zero        registered count-is-zero flag
module phase_timer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  output logic              zero
);

  logic [DATA_W-1:0] cnt;

  // zero tracks the count value it will hold next, so it is a flop rather
  // than a decode of cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      zero <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      zero <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      zero <= (load_val == '0);
    end else begin
      if (cnt != '0) cnt <= cnt - 1'b1;
      zero <= (cnt == DATA_W'(1));
    end
  end

endmodule

// File: rtl/phase_bus_reader.sv
// rtl/phase_bus_reader.sv - reads phase durations from register slots, then sequences phases
// Purpose: on start, polls each slot (REQ then CAP per slot) into a duration
//          table, then runs phases back to back, each for its captured
//          duration. reload re-reads the slots after the current phase cycle.
//          Optional macro ZERO_DUR_SUBST_EN: a captured 0 lasts DEFAULT_DUR
//          cycles instead of 1.
// Ports:
//   Clk      system clock, rising edge
//   Clear_n  asynchronous active-low reset
//   bus      phase_bus_reader_if.master (start, reload, bus_data, slot_rd,
//            loading, phase_active, phase_idx, phase_end)
module phase_bus_reader
  import phase_bus_reader_pkg::*;
#(
  parameter int NUM_PHASES  = 4,
  parameter int DATA_W      = 8,
  parameter int DEFAULT_DUR = DEFAULT_DUR_DEF
) (
  input  logic                 Clk,
  input  logic                 Clear_n,
  phase_bus_reader_if.master   bus
);

  localparam int                    IW       = idx_width(NUM_PHASES);
  localparam logic [IW-1:0]         LAST     = IW'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] ONE      = NUM_PHASES'(1);
  localparam logic [DATA_W-1:0]     SUBST_M1 = DATA_W'(DEFAULT_DUR - 1);
`ifdef ZERO_DUR_SUBST_EN
  localparam bit SUBST_EN = 1'b1;
`else
  localparam bit SUBST_EN = 1'b0;
`endif

  state_t                state;
  logic [IW-1:0]         slot_idx;
  logic [IW-1:0]         phase_idx;
  logic [IW-1:0]         next_phase;
  logic [NUM_PHASES-1:0] slot_rd;
  logic                  loading;
  logic                  phase_active;
  logic                  reload_pend;
  logic [DATA_W-1:0]     dur [NUM_PHASES];

  logic                  tmr_clr;
  logic                  tmr_load;
  logic [DATA_W-1:0]     tmr_val;
  logic                  tmr_zero;

  // Timer start value for a phase: effective duration minus one.
  function automatic logic [DATA_W-1:0] eff_m1(input logic [DATA_W-1:0] d);
    if (d != '0) return d - 1'b1;
    return SUBST_EN ? SUBST_M1 : '0;
  endfunction

  assign next_phase = phase_idx + 1'b1;

  // Timer is loaded on the edge that enters a phase, so the load decision
  // mirrors the FSM transitions below.
  always_comb begin
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      CAP: begin
        if (slot_idx == LAST) begin
          tmr_load = 1'b1;
          tmr_val  = eff_m1(dur[0]);
        end else begin
          tmr_clr = 1'b1;
        end
      end
      RUN: begin
        if (tmr_zero) begin
          if (phase_idx != LAST) begin
            tmr_load = 1'b1;
            tmr_val  = eff_m1(dur[next_phase]);
          end else if (reload_pend) begin
            tmr_clr = 1'b1;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = eff_m1(dur[0]);
          end
        end
      end
      default: tmr_clr = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state        <= IDLE;
      slot_idx     <= '0;
      phase_idx    <= '0;
      slot_rd      <= '0;
      loading      <= 1'b0;
      phase_active <= 1'b0;
      reload_pend  <= 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) dur[i] <= '0;
    end else begin
      if (bus.reload && state != IDLE) reload_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= REQ;
            slot_idx <= '0;
            slot_rd  <= ONE;
            loading  <= 1'b1;
          end
        end
        REQ: begin
          slot_rd <= '0;
          state   <= CAP;
        end
        CAP: begin
          dur[slot_idx] <= bus.bus_data;
          if (slot_idx != LAST) begin
            slot_idx <= slot_idx + 1'b1;
            slot_rd  <= ONE << (slot_idx + 1'b1);
            state    <= REQ;
          end else begin
            state        <= RUN;
            loading      <= 1'b0;
            phase_active <= 1'b1;
            phase_idx    <= '0;
          end
        end
        RUN: begin
          if (tmr_zero) begin
            if (phase_idx != LAST) begin
              phase_idx <= next_phase;
            end else if (reload_pend) begin
              // Overrides any reload arriving on this same edge.
              reload_pend  <= 1'b0;
              state        <= REQ;
              phase_active <= 1'b0;
              phase_idx    <= '0;
              slot_idx     <= '0;
              slot_rd      <= ONE;
              loading      <= 1'b1;
            end else begin
              phase_idx <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  phase_timer #(.DATA_W(DATA_W)) u_timer (
    .clk      (Clk),
    .rst_n    (Clear_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign bus.slot_rd      = slot_rd;
  assign bus.loading      = loading;
  assign bus.phase_active = phase_active;
  assign bus.phase_idx    = phase_idx;
  assign bus.phase_end    = tmr_zero;

endmodule
